effect_sequencer: RTL and testbench

//  Steps a latched 4-slot program of 4-bit decoration opcodes (slot0 = prog[3:0] .. slot3 = prog[15:12]).

---
 rtl/halloween_pkg.sv | 48 ++++
 rtl/dwell_timer.sv | 34 +++
 rtl/effect_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_effect_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halloween_pkg.sv
// Shared opcode encodings, class codes, FSM state type and fx bit positions for the
// effect sequencer.
package halloween_pkg;

    localparam logic [3:0] OpOn        = 4'h0;
    localparam logic [3:0] OpReset     = 4'h1;
    localparam logic [3:0] OpGreen     = 4'h4;
    localparam logic [3:0] OpPurple    = 4'h5;
    localparam logic [3:0] OpOrange    = 4'h6;
    localparam logic [3:0] OpScream    = 4'h8;
    localparam logic [3:0] OpCackle    = 4'h9;
    localparam logic [3:0] OpBoo       = 4'hA;
    localparam logic [3:0] OpWaveHands = 4'hC;
    localparam logic [3:0] OpMoveJaw   = 4'hD;
    localparam logic [3:0] OpFog       = 4'hE;

    localparam logic [1:0] ClsSys   = 2'b00;
    localparam logic [1:0] ClsColor = 2'b01;
    localparam logic [1:0] ClsSound = 2'b10;
    localparam logic [1:0] ClsFx    = 2'b11;

    localparam int unsigned FxWaveHands = 0;
    localparam int unsigned FxMoveJaw   = 1;
    localparam int unsigned FxFog       = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSoundWait,
        StDwell,
        StAdvance,
        StDone
    } state_e;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Item 11 is unused in every class; SYS only defines ON and RESET.
    function automatic logic op_illegal(logic [3:0] op);
        return (op[1:0] == 2'b11) || ((op[3:2] == ClsSys) && op[1]);
    endfunction

    function automatic logic [2:0] fx_onehot(logic [1:0] sel);
        return 3'(3'b001 << sel);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that parks at zero; expire_o is high while the count is zero.
// Shared between the colour/effect dwell and the sound acknowledge timeout.
module dwell_timer #(
    parameter int unsigned Width = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expire_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/effect_sequencer.sv
// Steps a latched 4-slot decoration program, driving colour, fx and sound requests.
// Define SEQ_LOOP_EN to make the program repeat from slot 3 back to slot 0.
module effect_sequencer
    import halloween_pkg::*;
#(
    parameter int unsigned DWELL       = 16,
    parameter int unsigned ACK_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] prog_i,
    input  logic        snd_ack_i,
    output logic        snd_req_o,
    output logic [1:0]  snd_id_o,
    output logic [1:0]  color_o,
    output logic        color_on_o,
    output logic [2:0]  fx_o,
    output logic [1:0]  slot_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(max_u(DWELL, ACK_TIMEOUT) + 1);
    // Loads are N-1 because the timer is also at zero during its final held cycle.
    localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] AckLoad   = CntW'(ACK_TIMEOUT - 1);

    state_e state_q, state_d;

    logic [15:0] prog_q, prog_d;
    logic [1:0]  slot_q, slot_d;
    logic [1:0]  color_q, color_d;
    logic        color_on_q, color_on_d;
    logic [2:0]  fx_q, fx_d;
    logic        snd_req_q, snd_req_d;
    logic [1:0]  snd_id_q, snd_id_d;
    logic        err_q, err_d;

    logic            tmr_load;
    logic [CntW-1:0] tmr_load_val;
    logic            tmr_expire;

    logic [3:0] op;
    logic       op_bad;

    assign op     = prog_q[{slot_q, 2'b00} +: 4];
    assign op_bad = op_illegal(op);

    dwell_timer #(
        .Width (CntW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StFetch: begin
                if (op_bad) begin
                    state_d = StAdvance;
                end else begin
                    unique case (op[3:2])
                        ClsSys:   state_d = op[0] ? StDone : StAdvance;
                        ClsSound: state_d = StSoundWait;
                        default:  state_d = StDwell;
                    endcase
                end
            end
            StSoundWait: begin
                if (snd_ack_i) begin
                    state_d = StDwell;
                end else if (tmr_expire) begin
                    state_d = StAdvance;
                end
            end
            StDwell: begin
                if (tmr_expire) state_d = StAdvance;
            end
            StAdvance: begin
`ifdef SEQ_LOOP_EN
                state_d = StFetch;
`else
                state_d = (slot_q == 2'd3) ? StDone : StFetch;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prog_d       = prog_q;
        slot_d       = slot_q;
        color_d      = color_q;
        color_on_d   = color_on_q;
        fx_d         = fx_q;
        snd_req_d    = snd_req_q;
        snd_id_d     = snd_id_q;
        err_d        = err_q;
        tmr_load     = 1'b0;
        tmr_load_val = DwellLoad;
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    prog_d = prog_i;
                    slot_d = 2'd0;
                    err_d  = 1'b0;
                end
            end
            StFetch: begin
                if (op_bad) begin
                    err_d = 1'b1;
                end else begin
                    unique case (op[3:2])
                        ClsSys: begin
                            if (op[0]) begin
                                color_d    = 2'd0;
                                color_on_d = 1'b0;
                                fx_d       = 3'd0;
                            end
                        end
                        ClsColor: begin
                            color_d    = op[1:0];
                            color_on_d = 1'b1;
                            tmr_load   = 1'b1;
                        end
                        ClsSound: begin
                            snd_req_d    = 1'b1;
                            snd_id_d     = op[1:0];
                            tmr_load     = 1'b1;
                            tmr_load_val = AckLoad;
                        end
                        default: begin
                            fx_d     = fx_onehot(op[1:0]);
                            tmr_load = 1'b1;
                        end
                    endcase
                end
            end
            StSoundWait: begin
                // Ack wins over a simultaneous timeout expiry.
                if (snd_ack_i) begin
                    snd_req_d = 1'b0;
                    tmr_load  = 1'b1;
                end else if (tmr_expire) begin
                    snd_req_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            StDwell: begin
                if (tmr_expire) fx_d = 3'd0;
            end
            StAdvance: begin
`ifdef SEQ_LOOP_EN
                slot_d = slot_q + 2'd1;
`else
                if (slot_q != 2'd3) slot_d = slot_q + 2'd1;
`endif
            end
            StDone:  fx_d = 3'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_q     <= '0;
            slot_q     <= '0;
            color_q    <= '0;
            color_on_q <= 1'b0;
            fx_q       <= '0;
            snd_req_q  <= 1'b0;
            snd_id_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            prog_q     <= prog_d;
            slot_q     <= slot_d;
            color_q    <= color_d;
            color_on_q <= color_on_d;
            fx_q       <= fx_d;
            snd_req_q  <= snd_req_d;
            snd_id_q   <= snd_id_d;
            err_q      <= err_d;
        end
    end

    assign snd_req_o  = snd_req_q;
    assign snd_id_o   = snd_id_q;
    assign color_o    = color_q;
    assign color_on_o = color_on_q;
    assign fx_o       = fx_q;
    assign slot_o     = slot_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Scoreboard bench: each test queues the expected output changes (value plus cycles since
// the previous change); a negedge monitor pops and checks whenever any output changes.
module tb_effect_sequencer;

    localparam int unsigned D = 4;
    localparam int unsigned A = 7;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] prog_i;
    logic        snd_ack_i;
    logic        snd_req_o;
    logic [1:0]  snd_id_o;
    logic [1:0]  color_o;
    logic        color_on_o;
    logic [2:0]  fx_o;
    logic [1:0]  slot_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    effect_sequencer #(
        .DWELL       (D),
        .ACK_TIMEOUT (A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .prog_i     (prog_i),
        .snd_ack_i  (snd_ack_i),
        .snd_req_o  (snd_req_o),
        .snd_id_o   (snd_id_o),
        .color_o    (color_o),
        .color_on_o (color_on_o),
        .fx_o       (fx_o),
        .slot_o     (slot_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] slot;
        logic [1:0] color;
        logic       on;
        logic [2:0] fx;
        logic       req;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        string name;
        vec_t  v;
        int    dt;   // 0: interval not checked
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor
    vec_t cur, last;
    logic seen = 1'b0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t e;

    always @(negedge clk) begin
        cyc = cyc + 1;
        cur = {busy_o, done_o, err_o, slot_o, color_o, color_on_o, fx_o, snd_req_o, snd_id_o};
        if (!seen || cur !== last) begin
            n_cmp = n_cmp + 1;
            if (q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_change: got %b want no change (cycle %0d)", cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur !== e.v || (e.dt != 0 && (cyc - last_cyc) != e.dt)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %b after %0d cycles, want %b after %0d cycles",
                             e.name, cur, cyc - last_cyc, e.v, e.dt);
                end
            end
            last     = cur;
            last_cyc = cyc;
            seen     = 1'b1;
        end
    end

    task automatic ex(input string name, input logic busy, input logic done, input logic err,
                      input logic [1:0] slot, input logic [1:0] color, input logic on,
                      input logic [2:0] fx, input logic req, input logic [1:0] id,
                      input int dt);
        exp_t r;
        r.name = name;
        r.v    = {busy, done, err, slot, color, on, fx, req, id};
        r.dt   = dt;
        q.push_back(r);
    endtask

    task automatic start_prog(input logic [15:0] p);
        @(posedge clk);
        #2;
        start_i = 1'b1;
        prog_i  = p;
        @(posedge clk);
        #2;
        start_i = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s_timeout: got %0d pending events, want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Output state left behind by the previous test (hand-tracked).
    logic [1:0] pid = 2'd0;

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        prog_i    = '0;
        snd_ack_i = 1'b0;
        ex("reset", 0, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, 2'd0, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        quiet(2);

`ifndef SEQ_LOOP_EN
        // 1: ON, GREEN, PURPLE, ORANGE
        ex("t1.go",     1, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, 2'd0, 0);
        ex("t1.s1",     1, 0, 0, 2'd1, 2'd0, 0, 3'b000, 0, 2'd0, 2);
        ex("t1.green",  1, 0, 0, 2'd1, 2'd0, 1, 3'b000, 0, 2'd0, 1);
        ex("t1.s2",     1, 0, 0, 2'd2, 2'd0, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t1.purple", 1, 0, 0, 2'd2, 2'd1, 1, 3'b000, 0, 2'd0, 1);
        ex("t1.s3",     1, 0, 0, 2'd3, 2'd1, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t1.orange", 1, 0, 0, 2'd3, 2'd2, 1, 3'b000, 0, 2'd0, 1);
        ex("t1.done",   1, 1, 0, 2'd3, 2'd2, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t1.idle",   0, 0, 0, 2'd3, 2'd2, 1, 3'b000, 0, 2'd0, 1);
        start_prog(16'h6540);
        drain("t1", 100);
        quiet(3);

        // 2: SCREAM in slot 1, ack on the 5th request cycle
        ex("t2.go",     1, 0, 0, 2'd0, 2'd2, 1, 3'b000, 0, 2'd0, 0);
        ex("t2.s1",     1, 0, 0, 2'd1, 2'd2, 1, 3'b000, 0, 2'd0, 2);
        ex("t2.req",    1, 0, 0, 2'd1, 2'd2, 1, 3'b000, 1, 2'd0, 1);
        ex("t2.ack",    1, 0, 0, 2'd1, 2'd2, 1, 3'b000, 0, 2'd0, 5);
        ex("t2.s2",     1, 0, 0, 2'd2, 2'd2, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t2.purple", 1, 0, 0, 2'd2, 2'd1, 1, 3'b000, 0, 2'd0, 1);
        ex("t2.s3",     1, 0, 0, 2'd3, 2'd1, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t2.done",   1, 1, 0, 2'd3, 2'd1, 1, 3'b000, 0, 2'd0, 2);
        ex("t2.idle",   0, 0, 0, 2'd3, 2'd1, 1, 3'b000, 0, 2'd0, 1);
        start_prog(16'h0580);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (snd_req_o) break;
        end
        repeat (4) @(posedge clk);
        #2;
        snd_ack_i = 1'b1;
        @(posedge clk);
        #2;
        snd_ack_i = 1'b0;
        drain("t2", 100);
        quiet(3);

        // 3: CACKLE with no ack -> timeout
        ex("t3.go",   1, 0, 0, 2'd0, 2'd1, 1, 3'b000, 0, 2'd0, 0);
        ex("t3.req",  1, 0, 0, 2'd0, 2'd1, 1, 3'b000, 1, 2'd1, 1);
        ex("t3.tmo",  1, 0, 1, 2'd0, 2'd1, 1, 3'b000, 0, 2'd1, A);
        ex("t3.s1",   1, 0, 1, 2'd1, 2'd1, 1, 3'b000, 0, 2'd1, 1);
        ex("t3.s2",   1, 0, 1, 2'd2, 2'd1, 1, 3'b000, 0, 2'd1, 2);
        ex("t3.s3",   1, 0, 1, 2'd3, 2'd1, 1, 3'b000, 0, 2'd1, 2);
        ex("t3.done", 1, 1, 1, 2'd3, 2'd1, 1, 3'b000, 0, 2'd1, 2);
        ex("t3.idle", 0, 0, 1, 2'd3, 2'd1, 1, 3'b000, 0, 2'd1, 1);
        start_prog(16'h0009);
        drain("t3", 100);
        quiet(3);
        pid = 2'd1;
`endif

        // 4: GREEN, WAVEHANDS, RESET, FOG(skipped)
`ifdef SEQ_LOOP_EN
        ex("t4.go",    1, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, pid, 0);
        ex("t4.green", 1, 0, 0, 2'd0, 2'd0, 1, 3'b000, 0, pid, 1);
`else
        ex("t4.go",    1, 0, 0, 2'd0, 2'd1, 1, 3'b000, 0, pid, 0);
        ex("t4.green", 1, 0, 0, 2'd0, 2'd0, 1, 3'b000, 0, pid, 1);
`endif
        ex("t4.s1",    1, 0, 0, 2'd1, 2'd0, 1, 3'b000, 0, pid, D + 1);
        ex("t4.fx",    1, 0, 0, 2'd1, 2'd0, 1, 3'b001, 0, pid, 1);
        ex("t4.fxoff", 1, 0, 0, 2'd1, 2'd0, 1, 3'b000, 0, pid, D);
        ex("t4.s2",    1, 0, 0, 2'd2, 2'd0, 1, 3'b000, 0, pid, 1);
        ex("t4.reset", 1, 1, 0, 2'd2, 2'd0, 0, 3'b000, 0, pid, 1);
        ex("t4.idle",  0, 0, 0, 2'd2, 2'd0, 0, 3'b000, 0, pid, 1);
        start_prog(16'hE1C4);
        drain("t4", 100);
        quiet(3);

        // 5: illegal opcodes, start while busy, rst mid-dwell
        ex("t5.go",    1, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, pid, 0);
        ex("t5.s1",    1, 0, 0, 2'd1, 2'd0, 0, 3'b000, 0, pid, 2);
        ex("t5.ill3",  1, 0, 1, 2'd1, 2'd0, 0, 3'b000, 0, pid, 1);
        ex("t5.s2",    1, 0, 1, 2'd2, 2'd0, 0, 3'b000, 0, pid, 1);
        ex("t5.s3",    1, 0, 1, 2'd3, 2'd0, 0, 3'b000, 0, pid, 2);
        ex("t5.green", 1, 0, 1, 2'd3, 2'd0, 1, 3'b000, 0, pid, 1);
        ex("t5.rst",   0, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, 2'd0, 1);
        start_prog(16'h4F30);
        repeat (5) @(posedge clk);
        #2;
        start_i = 1'b1;
        prog_i  = 16'h0001;
        @(posedge clk);
        #2;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        drain("t5", 100);
        quiet(3);

`ifdef SEQ_LOOP_EN
        // 6: program repeats, no done pulse
        ex("t6.go",     1, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, 2'd0, 0);
        ex("t6.s1",     1, 0, 0, 2'd1, 2'd0, 0, 3'b000, 0, 2'd0, 2);
        ex("t6.green",  1, 0, 0, 2'd1, 2'd0, 1, 3'b000, 0, 2'd0, 1);
        ex("t6.s2",     1, 0, 0, 2'd2, 2'd0, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t6.purple", 1, 0, 0, 2'd2, 2'd1, 1, 3'b000, 0, 2'd0, 1);
        ex("t6.s3",     1, 0, 0, 2'd3, 2'd1, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t6.orange", 1, 0, 0, 2'd3, 2'd2, 1, 3'b000, 0, 2'd0, 1);
        ex("t6.wrap",   1, 0, 0, 2'd0, 2'd2, 1, 3'b000, 0, 2'd0, D + 1);
        ex("t6.s1b",    1, 0, 0, 2'd1, 2'd2, 1, 3'b000, 0, 2'd0, 2);
        ex("t6.green2", 1, 0, 0, 2'd1, 2'd0, 1, 3'b000, 0, 2'd0, 1);
        ex("t6.s2b",    1, 0, 0, 2'd2, 2'd0, 1, 3'b000, 0, 2'd0, D + 1);
        start_prog(16'h6540);
        drain("t6", 100);
        ex("t6.rst",    0, 0, 0, 2'd0, 2'd0, 0, 3'b000, 0, 2'd0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        drain("t6rst", 10);
        quiet(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
